// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and FSM state type for the FFT sample loader
package fft_pkg;

  localparam int          FFT_N       = 16;
  localparam int          FFT_NRES    = 4;
  localparam logic [13:0] FFT_WR_ADDR = 14'h098;
  localparam logic [13:0] FFT_RD_ADDR = 14'h088;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    SETTLE,
    READ,
    OUT
  } fft_state_t;

endpackage

// File: rtl/fft_loader.sv
// rtl/fft_loader.sv - peripheral-bus initiator: push 16 samples to the FFT, stream 4 result words back (optional zero padding via FFT_LOADER_ZPAD_EN)
module fft_loader
  import fft_pkg::*;
#(
  parameter logic [13:0] WR_ADDR = FFT_WR_ADDR,
  parameter logic [13:0] RD_ADDR = FFT_RD_ADDR
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [13:0] per_addr,
  output logic [15:0] per_din,
  output logic        per_en,
  output logic [1:0]  per_we,
  input  logic [15:0] per_dout,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_IDX = 5'(FFT_N - 1);
  localparam logic [1:0] LAST_RES = 2'(FFT_NRES - 1);

  fft_state_t  state, state_nxt;
  logic [4:0]  cnt, cnt_nxt, cnt_inc;
  logic [1:0]  k, k_nxt;
  logic        done_nxt;
  logic        pad_req;
  logic [13:0] rd_addr;

  assign cnt_inc = cnt + 5'd1;
  assign rd_addr = RD_ADDR + {12'd0, k};
  assign busy    = (state != IDLE);

`ifdef FFT_LOADER_ZPAD_EN
  assign pad_req = s_last;
`else
  // Early end of frame is not honoured in this build; the port stays for drop-in compatibility.
  assign pad_req = s_last & 1'b0;
`endif

  // State, counters, done pulse and result capture; reset aborts any frame in flight.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      k      <= 2'd0;
      done   <= 1'b0;
      m_data <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      k     <= k_nxt;
      done  <= done_nxt;
      if (state == READ) begin
        m_data <= per_dout;
      end
    end
  end

  // Next state plus bus/stream drive; the bus is quiet whenever no write or read is issued.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    k_nxt     = k;
    done_nxt  = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    per_en    = 1'b0;
    per_we    = 2'b00;
    per_addr  = 14'd0;
    per_din   = 16'd0;
    if (!puc_rst) begin
      case (state)
        IDLE, LOAD: begin
          s_ready = 1'b1;
          if (s_valid) begin
            per_en   = 1'b1;
            per_we   = 2'b11;
            per_addr = WR_ADDR;
            per_din  = s_data;
            cnt_nxt  = cnt_inc;
            if (cnt == LAST_IDX) begin
              state_nxt = SETTLE;
              cnt_nxt   = 5'd0;
            end else if (pad_req && (cnt_inc < LAST_IDX)) begin
              state_nxt = PAD;
            end else begin
              state_nxt = LOAD;
            end
          end
        end
`ifdef FFT_LOADER_ZPAD_EN
        PAD: begin
          per_en   = 1'b1;
          per_we   = 2'b11;
          per_addr = WR_ADDR;
          per_din  = 16'd0;
          cnt_nxt  = cnt_inc;
          if (cnt == LAST_IDX) begin
            state_nxt = SETTLE;
            cnt_nxt   = 5'd0;
          end
        end
`endif
        SETTLE: begin
          // One bus-idle cycle so the FFT input registers settle before reading results.
          state_nxt = READ;
        end
        READ: begin
          per_en    = 1'b1;
          per_addr  = rd_addr;
          state_nxt = OUT;
        end
        OUT: begin
          m_valid = 1'b1;
          m_last  = (k == LAST_RES);
          if (m_ready) begin
            if (k == LAST_RES) begin
              state_nxt = IDLE;
              k_nxt     = 2'd0;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = READ;
              k_nxt     = k + 2'd1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_loader.sv
// tb/tb_fft_loader.sv - directed self-checking bench for fft_loader
module tb_fft_loader;
  import fft_pkg::*;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic [15:0] s_data = 16'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_last = 1'b0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [15:0] wr_d[$];
  logic [13:0] wr_a[$];
  logic [13:0] rd_a[$];
  logic [15:0] exp_d[16];

  fft_loader dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_last   (s_last),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .busy     (busy),
    .done     (done)
  );

  always #5 mclk = ~mclk;

  // FFT result bank model
  always_comb begin
    case (per_addr)
      14'h088: per_dout = 16'h1111;
      14'h089: per_dout = 16'h2222;
      14'h08A: per_dout = 16'h3333;
      14'h08B: per_dout = 16'h4444;
      default: per_dout = 16'hDEAD;
    endcase
  end

  // Bus transaction monitor, sampled mid-cycle
  always @(negedge mclk) begin
    if (!puc_rst && per_en) begin
      if (per_we == 2'b11) begin
        wr_d.push_back(per_din);
        wr_a.push_back(per_addr);
      end else if (per_we == 2'b00) begin
        rd_a.push_back(per_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic align();
    @(posedge mclk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic push(input logic [15:0] d, input logic last);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    @(negedge mclk);
    while (!s_ready && n < 50) begin
      @(negedge mclk);
      n++;
    end
    chk("push handshake", {31'd0, s_ready}, 32'd1);
    align();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic settle_check(input string tag);
    @(negedge mclk);
    chk({tag, " settle per_en"}, {31'd0, per_en}, 32'd0);
    chk({tag, " settle s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, " settle busy"}, {31'd0, busy}, 32'd1);
    @(negedge mclk);
    chk({tag, " read0 en"}, {31'd0, per_en}, 32'd1);
    chk({tag, " read0 we"}, {30'd0, per_we}, 32'd0);
    chk({tag, " read0 addr"}, {18'd0, per_addr}, 32'h088);
  endtask

  task automatic read_out(input string tag, input int stall);
    logic [15:0] exp_r[4];
    int n, nrd, nwr;
    exp_r[0] = 16'h1111;
    exp_r[1] = 16'h2222;
    exp_r[2] = 16'h3333;
    exp_r[3] = 16'h4444;
    m_ready = (stall == 0);
    for (int j = 0; j < 4; j++) begin
      n = 0;
      @(negedge mclk);
      while (!m_valid && n < 20) begin
        @(negedge mclk);
        n++;
      end
      chk({tag, " m_valid"}, {31'd0, m_valid}, 32'd1);
      chk({tag, " m_data"}, {16'd0, m_data}, {16'd0, exp_r[j]});
      chk({tag, " m_last"}, {31'd0, m_last}, (j == 3) ? 32'd1 : 32'd0);
      if (j == 0 && stall > 0) begin
        nrd     = rd_a.size();
        nwr     = wr_d.size();
        s_data  = 16'hBEEF;
        s_valid = 1'b1;
        for (int s = 0; s < stall; s++) begin
          @(negedge mclk);
          chk({tag, " stall m_valid"}, {31'd0, m_valid}, 32'd1);
          chk({tag, " stall m_data"}, {16'd0, m_data}, 32'h1111);
          chk({tag, " stall s_ready"}, {31'd0, s_ready}, 32'd0);
        end
        s_valid = 1'b0;
        chk({tag, " stall no reads"}, rd_a.size(), nrd);
        chk({tag, " stall no writes"}, wr_d.size(), nwr);
        m_ready = 1'b1;
      end
    end
    @(negedge mclk);
    chk({tag, " done pulse"}, {31'd0, done}, 32'd1);
    chk({tag, " busy after"}, {31'd0, busy}, 32'd0);
    chk({tag, " m_valid after"}, {31'd0, m_valid}, 32'd0);
    @(negedge mclk);
    chk({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    chk({tag, " read count"}, rd_a.size(), 32'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < rd_a.size()) chk({tag, " read addr"}, {18'd0, rd_a[j]}, 32'h088 + j);
    end
    rd_a.delete();
  endtask

  task automatic check_writes(input string tag);
    int bad_a, bad_d;
    bad_a = 0;
    bad_d = 0;
    chk({tag, " write count"}, wr_d.size(), 32'd16);
    foreach (wr_d[i]) begin
      if (i < 16 && wr_d[i] !== exp_d[i]) bad_d++;
      if (wr_a[i] !== 14'h098) bad_a++;
    end
    chk({tag, " write data order"}, bad_d, 32'd0);
    chk({tag, " write addr"}, bad_a, 32'd0);
    wr_d.delete();
    wr_a.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge mclk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst m_data", {16'd0, m_data}, 32'd0);
    chk("rst per_en", {31'd0, per_en}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    align();
    puc_rst = 1'b0;
    @(negedge mclk);
    chk("idle s_ready", {31'd0, s_ready}, 32'd1);
    chk("idle busy", {31'd0, busy}, 32'd0);
    align();

    // Frame 1: back-to-back 0x0001..0x0010, m_ready held high
    for (int i = 0; i < 16; i++) exp_d[i] = 16'(i + 1);
    for (int i = 0; i < 16; i++) push(16'(i + 1), 1'b0);
    settle_check("f1");
    read_out("f1", 0);
    check_writes("f1");
    align();

    // Frame 2: valid 1-of-3 cycles, 5-cycle output stall with s_valid held during OUT
    for (int i = 0; i < 16; i++) exp_d[i] = 16'h0100 + 16'(i);
    for (int i = 0; i < 16; i++) begin
      push(16'h0100 + 16'(i), 1'b0);
      if (i < 15) begin
        @(negedge mclk);
        chk("f2 busy mid-frame", {31'd0, busy}, 32'd1);
        align();
        align();
      end
    end
    settle_check("f2");
    read_out("f2", 5);
    check_writes("f2");
    align();

    // Frame 3: early s_last on sample 5
`ifdef FFT_LOADER_ZPAD_EN
    for (int i = 0; i < 16; i++) exp_d[i] = (i < 5) ? 16'h0200 + 16'(i) : 16'd0;
    for (int i = 0; i < 5; i++) push(16'h0200 + 16'(i), (i == 4));
    for (int i = 0; i < 11; i++) begin
      @(negedge mclk);
      chk("f3 pad en", {31'd0, per_en}, 32'd1);
      chk("f3 pad din", {16'd0, per_din}, 32'd0);
      chk("f3 pad s_ready", {31'd0, s_ready}, 32'd0);
    end
`else
    for (int i = 0; i < 16; i++) exp_d[i] = 16'h0200 + 16'(i);
    for (int i = 0; i < 16; i++) begin
      push(16'h0200 + 16'(i), (i == 4));
      if (i == 4) begin
        @(negedge mclk);
        chk("f3 s_last ignored s_ready", {31'd0, s_ready}, 32'd1);
        chk("f3 s_last ignored busy", {31'd0, busy}, 32'd1);
        align();
      end
    end
`endif
    settle_check("f3");
    read_out("f3", 0);
    check_writes("f3");
    align();

    // Frame 4: reset after 7 writes, then a fresh full frame
    for (int i = 0; i < 7; i++) push(16'h0300 + 16'(i), 1'b0);
    puc_rst = 1'b1;
    @(negedge mclk);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst m_data", {16'd0, m_data}, 32'd0);
    chk("midrst per_en", {31'd0, per_en}, 32'd0);
    chk("midrst per_addr", {18'd0, per_addr}, 32'd0);
    chk("midrst per_we", {30'd0, per_we}, 32'd0);
    chk("midrst m_valid", {31'd0, m_valid}, 32'd0);
    align();
    puc_rst = 1'b0;
    wr_d.delete();
    wr_a.delete();
    rd_a.delete();
    for (int i = 0; i < 16; i++) exp_d[i] = 16'h0400 + 16'(i);
    for (int i = 0; i < 16; i++) push(16'h0400 + 16'(i), 1'b0);
    settle_check("f4");
    read_out("f4", 0);
    check_writes("f4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
